// File: rtl/cpu_apb_pkg.sv
// rtl/cpu_apb_pkg.sv - shared types and constants for the CPU APB initiator
//
// Purpose: state encoding, bus widths and timeout defaults shared by the
// APB initiator and anything that instantiates it.
//
// Contents:
//   apb_state_t          IDLE / SETUP / ACCESS / RESP
//   APB_ADDR_W           APB address width (32)
//   APB_DATA_W           APB data width (32)
//   APB_TIMEOUT_DEFAULT  default ACCESS-phase cycle limit (256)
//   APB_TMO_W            width of the ACCESS-phase cycle counter (16)
//   apb_tmo_last()       counter value at which the transfer is abandoned
package cpu_apb_pkg;

   localparam int APB_ADDR_W          = 32;
   localparam int APB_DATA_W          = 32;
   localparam int APB_TIMEOUT_DEFAULT = 256;
   localparam int APB_TMO_W           = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_t;

   // The counter reads 0 in the first ACCESS cycle, so a limit of N cycles
   // is reached when it reads N-1. A limit of 0 means "no limit"; the value
   // returned then is irrelevant because the caller gates on the limit.
   function automatic logic [APB_TMO_W-1:0] apb_tmo_last(input int unsigned cyc);
      logic [31:0] last;
      last = (cyc == 0) ? 32'd0 : cyc - 32'd1;
      return last[APB_TMO_W-1:0];
   endfunction

endpackage

// File: rtl/cpu_apb_master.sv
// rtl/cpu_apb_master.sv - single-beat APB initiator with wait-state timeout
//
// Purpose: accepts one CPU read/write request at a time, runs it as an APB
// SETUP/ACCESS transfer, and returns read data plus an error flag.
//
// Ports:
//   i_clk, i_rst                      clock, asynchronous active-high reset
//   i_req_valid/o_req_ready           request handshake
//   i_req_write/i_req_addr/i_req_wdata request payload
//   o_rsp_valid/i_rsp_ready           response handshake
//   o_rsp_rdata/o_rsp_err             response payload
//   o_psel/o_penable/o_pwrite         APB control
//   o_paddr/o_pwdata                  APB address / write data
//   i_prdata/i_pready/i_pslverr       APB completion from the slave
module cpu_apb_master
   import cpu_apb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_DEFAULT
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_write,
   input  logic [APB_ADDR_W-1:0] i_req_addr,
   input  logic [APB_DATA_W-1:0] i_req_wdata,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [APB_DATA_W-1:0] o_rsp_rdata,
   output logic                  o_rsp_err,
   output logic                  o_psel,
   output logic                  o_penable,
   output logic                  o_pwrite,
   output logic [APB_ADDR_W-1:0] o_paddr,
   output logic [APB_DATA_W-1:0] o_pwdata,
   input  logic [APB_DATA_W-1:0] i_prdata,
   input  logic                  i_pready,
   input  logic                  i_pslverr
);

   localparam logic                 TMO_EN   = (TIMEOUT_CYC != 0);
   localparam logic [APB_TMO_W-1:0] TMO_LAST = apb_tmo_last(TIMEOUT_CYC);

   apb_state_t            state_q,     state_d;
   logic                  req_ready_q, req_ready_d;
   logic                  psel_q,      psel_d;
   logic                  penable_q,   penable_d;
   logic                  pwrite_q,    pwrite_d;
   logic [APB_ADDR_W-1:0] paddr_q,     paddr_d;
   logic [APB_DATA_W-1:0] pwdata_q,    pwdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q,   rsp_err_d;
   logic [APB_TMO_W-1:0]  tmo_cnt_q,   tmo_cnt_d;

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      tmo_cnt_d   = tmo_cnt_q;

      unique case (state_q)
         IDLE: begin
            // req_ready_q is low for the first cycle out of reset, so an
            // accept needs both the idle state and the registered ready.
            if (req_ready_q && i_req_valid) begin
               pwrite_d  = i_req_write;
               paddr_d   = i_req_addr;
               pwdata_d  = i_req_wdata;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               tmo_cnt_d = '0;
               state_d   = SETUP;
            end
         end

         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end

         ACCESS: begin
            // Saturate rather than wrap so a disabled timeout cannot alias.
            if (tmo_cnt_q != '1) begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
            // A slave completing on the last allowed cycle still wins.
            if (i_pready) begin
               rsp_rdata_d = pwrite_q ? '0 : i_prdata;
               rsp_err_d   = i_pslverr;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end

         RESP: begin
            if (i_rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Registered from the next state so the output is a plain flop that
      // still tracks the state exactly.
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         tmo_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         tmo_cnt_q   <= tmo_cnt_d;
      end
   end

   assign o_req_ready = req_ready_q;
   assign o_psel      = psel_q;
   assign o_penable   = penable_q;
   assign o_pwrite    = pwrite_q;
   assign o_paddr     = paddr_q;
   assign o_pwdata    = pwdata_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_cpu_apb_master.sv
// tb/tb_cpu_apb_master.sv - self-checking bench for cpu_apb_master
module tb_cpu_apb_master;

   localparam int TO = 8;

   localparam int P_IDLE   = 0;
   localparam int P_SETUP  = 1;
   localparam int P_ACCESS = 2;
   localparam int P_RESP   = 3;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_req_valid = 1'b0;
   logic        o_req_ready;
   logic        i_req_write = 1'b0;
   logic [31:0] i_req_addr = '0;
   logic [31:0] i_req_wdata = '0;
   logic        o_rsp_valid;
   logic        i_rsp_ready = 1'b0;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_err;
   logic        o_psel;
   logic        o_penable;
   logic        o_pwrite;
   logic [31:0] o_paddr;
   logic [31:0] o_pwdata;
   logic [31:0] i_prdata;
   logic        i_pready;
   logic        i_pslverr;

   cpu_apb_master #(.TIMEOUT_CYC(TO)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_write (i_req_write),
      .i_req_addr  (i_req_addr),
      .i_req_wdata (i_req_wdata),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_rdata (o_rsp_rdata),
      .o_rsp_err   (o_rsp_err),
      .o_psel      (o_psel),
      .o_penable   (o_penable),
      .o_pwrite    (o_pwrite),
      .o_paddr     (o_paddr),
      .o_pwdata    (o_pwdata),
      .i_prdata    (i_prdata),
      .i_pready    (i_pready),
      .i_pslverr   (i_pslverr)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Configuration-register slave: 16 words, word 3 (addr 0x0C) resets to 50000.
   logic [31:0] mem [16];
   int          slv_waited;
   int          slv_wait_cfg = 0;
   logic        slv_stuck = 1'b0;
   logic        slv_err = 1'b0;
   logic        slv_ovr = 1'b0;
   logic [31:0] slv_ovr_data = '0;
   logic [31:0] slv_last_wdata;

   assign i_pready  = !slv_stuck && (slv_waited >= slv_wait_cfg);
   assign i_pslverr = slv_err;
   assign i_prdata  = slv_ovr ? slv_ovr_data : mem[o_paddr[5:2]];

   always @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < 16; k++) mem[k] <= '0;
         mem[3]         <= 32'd50000;
         slv_waited     <= 0;
         slv_last_wdata <= '0;
      end else begin
         if (o_psel && o_penable && !i_pready) slv_waited <= slv_waited + 1;
         else if (!(o_psel && o_penable))       slv_waited <= 0;
         if (o_psel && o_penable && i_pready && o_pwrite) begin
            mem[o_paddr[5:2]] <= o_pwdata;
            slv_last_wdata    <= o_pwdata;
         end
      end
   end

   // Reference model: walks each request through the protocol phases using
   // the inputs seen before each edge, and checks every output each cycle.
   int          m_ph = P_IDLE;
   int          m_cnt = 0;
   logic        m_live = 1'b0;
   logic        m_write = 1'b0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_wdata = '0;
   logic [31:0] m_rdata = '0;
   logic        m_err = 1'b0;
   int          pen_cnt = 0;

   initial begin : model
      forever begin
         @(negedge i_clk);
         if (i_rst) begin
            chk("rst_req_ready", o_req_ready, 0);
            chk("rst_psel",      o_psel, 0);
            chk("rst_penable",   o_penable, 0);
            chk("rst_rsp_valid", o_rsp_valid, 0);
            chk("rst_paddr",     o_paddr, 0);
            m_ph = P_IDLE; m_cnt = 0; m_live = 1'b0;
            m_write = 1'b0; m_addr = '0; m_wdata = '0;
            m_rdata = '0; m_err = 1'b0;
         end else begin
            if (o_penable) pen_cnt++;
            chk("m_req_ready", o_req_ready, (m_live && m_ph == P_IDLE));
            chk("m_psel",      o_psel, (m_ph == P_SETUP || m_ph == P_ACCESS));
            chk("m_penable",   o_penable, (m_ph == P_ACCESS));
            chk("m_rsp_valid", o_rsp_valid, (m_ph == P_RESP));
            chk("m_pwrite",    o_pwrite, m_write);
            chk("m_paddr",     o_paddr, m_addr);
            chk("m_pwdata",    o_pwdata, m_wdata);
            if (m_ph == P_RESP) begin
               chk("m_rsp_rdata", o_rsp_rdata, m_rdata);
               chk("m_rsp_err",   o_rsp_err, m_err);
            end
            if (m_ph == P_IDLE) begin
               if (m_live && i_req_valid) begin
                  m_write = i_req_write; m_addr = i_req_addr; m_wdata = i_req_wdata;
                  m_ph = P_SETUP;
               end
            end else if (m_ph == P_SETUP) begin
               m_ph = P_ACCESS; m_cnt = 0;
            end else if (m_ph == P_ACCESS) begin
               if (i_pready) begin
                  m_rdata = m_write ? 32'd0 : i_prdata;
                  m_err = i_pslverr;
                  m_ph = P_RESP;
               end else if (TO != 0 && m_cnt == TO - 1) begin
                  m_rdata = '0; m_err = 1'b1; m_ph = P_RESP;
               end else begin
                  m_cnt++;
               end
            end else begin
               if (i_rsp_ready) m_ph = P_IDLE;
            end
            m_live = 1'b1;
         end
      end
   end

   // Called and returns at posedge+1. Checks the response payload and the
   // accept-to-response latency against caller-supplied literals.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int hold, input logic [31:0] exp_rd, input logic exp_er,
                       input int exp_lat, input string tag, output int acc_cyc);
      logic ok;
      i_req_valid = 1'b1; i_req_write = w; i_req_addr = a; i_req_wdata = d;
      i_rsp_ready = (hold == 0);
      acc_cyc = -1;
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge i_clk);
         if (o_req_ready) ok = 1'b1;
      end
      if (!ok) begin
         chk({tag, "_accept"}, o_req_ready, 1);
         i_req_valid = 1'b0;
         return;
      end
      acc_cyc = cyc;
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge i_clk);
         if (o_rsp_valid) ok = 1'b1;
      end
      chk({tag, "_rsp_seen"}, o_rsp_valid, 1);
      if (!ok) return;
      chk({tag, "_latency"}, cyc - acc_cyc, exp_lat);
      chk({tag, "_rdata"}, o_rsp_rdata, exp_rd);
      chk({tag, "_err"}, o_rsp_err, exp_er);
      if (hold > 0) begin
         for (int k = 1; k < hold; k++) begin
            @(negedge i_clk);
            chk({tag, "_hold_valid"}, o_rsp_valid, 1);
            chk({tag, "_hold_ready"}, o_req_ready, 0);
            chk({tag, "_hold_rdata"}, o_rsp_rdata, exp_rd);
            chk({tag, "_hold_err"}, o_rsp_err, exp_er);
         end
         @(posedge i_clk); #1;
         i_rsp_ready = 1'b1;
         @(negedge i_clk);
      end
      @(posedge i_clk); #1;
      i_rsp_ready = 1'b0;
   endtask

   int a1, a2, a3;
   logic ok_flag;

   initial begin : stim
      repeat (3) @(posedge i_clk);
      #1;
      chk("reset_ready", o_req_ready, 0);
      chk("reset_psel", o_psel, 0);
      chk("reset_rsp_valid", o_rsp_valid, 0);
      chk("reset_paddr", o_paddr, 0);
      i_rst = 1'b0;
      @(posedge i_clk); #1;
      chk("ready_after_rst", o_req_ready, 1);

      // Write then read back, back to back: 4-cycle throughput.
      xfer(1'b1, 32'h04, 32'h0000_1000, 0, 32'h0, 1'b0, 3, "wr04", a1);
      chk("wr04_pwdata", slv_last_wdata, 32'h0000_1000);
      xfer(1'b0, 32'h04, 32'h0, 0, 32'h0000_1000, 1'b0, 3, "rd04", a2);
      chk("throughput", a2 - a1, 4);

      xfer(1'b0, 32'h0C, 32'h0, 0, 32'h0000_C350, 1'b0, 3, "rd0c", a3);

      // Five wait states: penable for 6 cycles.
      slv_wait_cfg = 5; pen_cnt = 0;
      xfer(1'b0, 32'h04, 32'h0, 0, 32'h0000_1000, 1'b0, 8, "wait5", a3);
      chk("wait5_pen_cnt", pen_cnt, 6);

      // Ready arriving on the last allowed cycle beats the timeout.
      slv_wait_cfg = 7; pen_cnt = 0;
      xfer(1'b0, 32'h04, 32'h0, 0, 32'h0000_1000, 1'b0, 10, "wait7", a3);
      chk("wait7_pen_cnt", pen_cnt, 8);
      slv_wait_cfg = 0;

      // Stuck slave: timeout after 8 ACCESS cycles, then a normal transfer.
      slv_stuck = 1'b1; slv_ovr = 1'b1; slv_ovr_data = 32'h1234_5678; pen_cnt = 0;
      xfer(1'b0, 32'h08, 32'h0, 0, 32'h0, 1'b1, 10, "tmo", a3);
      chk("tmo_pen_cnt", pen_cnt, 8);
      chk("tmo_psel_low", o_psel, 0);
      slv_stuck = 1'b0; slv_ovr = 1'b0;
      xfer(1'b0, 32'h04, 32'h0, 0, 32'h0000_1000, 1'b0, 3, "post_tmo", a3);

      // Slave error on a read, response held for 4 cycles.
      slv_err = 1'b1; slv_ovr = 1'b1; slv_ovr_data = 32'hDEAD_BEEF;
      xfer(1'b0, 32'h10, 32'h0, 4, 32'hDEAD_BEEF, 1'b1, 3, "slverr", a3);

      // Write response carries zero data even if the slave drives prdata.
      slv_err = 1'b0; slv_ovr_data = 32'h0000_A5A5;
      xfer(1'b1, 32'h14, 32'h0000_0055, 0, 32'h0, 1'b0, 3, "wr14", a3);
      slv_ovr = 1'b0;
      chk("wr14_pwdata", slv_last_wdata, 32'h0000_0055);

      // Reset during ACCESS.
      slv_stuck = 1'b1;
      i_req_valid = 1'b1; i_req_write = 1'b0; i_req_addr = 32'h0C; i_rsp_ready = 1'b1;
      ok_flag = 1'b0;
      for (int n = 0; n < 50 && !ok_flag; n++) begin
         @(negedge i_clk);
         if (o_penable) ok_flag = 1'b1;
         if (o_psel) i_req_valid = 1'b0;
      end
      chk("rst_mid_reached_access", o_penable, 1);
      i_req_valid = 1'b0;
      @(posedge i_clk); #1;
      i_rst = 1'b1;
      #1;
      chk("rst_mid_psel", o_psel, 0);
      chk("rst_mid_penable", o_penable, 0);
      chk("rst_mid_rsp_valid", o_rsp_valid, 0);
      chk("rst_mid_ready", o_req_ready, 0);
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0; slv_stuck = 1'b0;
      @(posedge i_clk); #1;
      chk("rst_mid_ready_after", o_req_ready, 1);
      chk("rst_mid_no_rsp", o_rsp_valid, 0);
      i_rsp_ready = 1'b0;
      xfer(1'b0, 32'h0C, 32'h0, 0, 32'h0000_C350, 1'b0, 3, "post_rst", a3);

      repeat (3) @(posedge i_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
